iob2axi_rd_split: RTL
=====================

Name: iob2axi_rd_split

Overview:
Upstream control stage for the AXI read engine. Takes one arbitrary-length, word-aligned read request and splits it into legal AXI4 INCR bursts: each burst is at most MAX_BURST beats and never crosses a BOUNDARY-byte boundary. It issues the bursts one at a time over the engine's run/addr/length/ready/error control interface and reports overall completion and error to its client.

Parameters:
ADDR_W, 32, byte address width.
DATA_W, 32, data width; beat size is DATA_W/8 bytes (power of two).
CNT_W, 16, width of the word-count request.
MAX_BURST, 256, max beats per burst (1..256).
BOUNDARY, 4096, bytes; no burst crosses a multiple of this.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
start  in  1  request strobe; sampled only in IDLE.
base_addr  in  ADDR_W  start byte address.
nwords  in  CNT_W  number of beats to read.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  sticky error for the current/last request.
run  out  1  burst request to the engine.
addr  out  ADDR_W  burst start address.
length  out  AXI_LEN_W  burst beats minus 1.
ready  in  1  engine idle / accepting.
error  in  1  engine result of last burst.

Behaviour:
- Reset values: busy=0, done=0, err=0, run=0, addr=0, length=0; state=IDLE; internal counters 0.
- Engine protocol: run is held high while in ISSUE and ready=1. The first cycle with ready=0 in ISSUE means the request was accepted; in that cycle run=0. ready returning to 1 in WAIT means the burst is complete; error is valid in that same cycle.
- Idle behaviour:
  - IDLE: on start, latch cur_addr=base_addr and rem=nwords; clear err; go to CALC.
  - If base_addr has any of its low log2(DATA_W/8) bits set, go to DONE with err=1 and issue no burst.
  - If nwords=0, go to DONE with err=0.
- CALC (1 cycle):
  - beats_to_bnd = (BOUNDARY - (cur_addr mod BOUNDARY)) >> log2(DATA_W/8).
  - blen = min(rem, MAX_BURST, beats_to_bnd).
  - Register addr=cur_addr and length=blen-1; go to ISSUE.
- ISSUE: run=1 until acceptance is seen, then go to WAIT.
- WAIT: on ready=1:
  - Update cur_addr += blen*(DATA_W/8), wrapping mod 2^ADDR_W.
  - Update rem -= blen.
  - If error=1: set err=1 and go to DONE, issuing no further bursts.
  - Else if rem=0: go to DONE.
  - Else: go to CALC.
- DONE: done=1 for exactly one cycle, then IDLE. err holds until the next start.
- Latency: start accepted at edge N; run first high in cycle N+2. done is high the cycle after the last completion is observed.
- Widths: blen is $clog2(MAX_BURST)+1 bits; length = blen-1 always fits AXI_LEN_W. rem is CNT_W bits and never underflows because blen<=rem.
- start while busy=1 is ignored. Inputs base_addr and nwords are sampled only at the accepting start.
- rst mid-operation: on the next edge everything returns to reset values. run drops immediately after that edge. The engine must be reset together with this block.

Decomposition:
- Shared package/include: AXI_LEN_W (from the existing axi include), the state encodings IDLE/CALC/ISSUE/WAIT/DONE, and the default BOUNDARY constant.
- One natural sub-module: iob2axi_burst_len. It is purely combinational: cur_addr and rem in, blen out (the min of three operands). Its output is registered by the parent in CALC.

Test Plan:
1. DATA_W=32, base 0x0, nwords 16 -> one burst, addr=0x0 length=15; done pulse; err=0.
2. base 0x0, nwords 600 -> three bursts: 0x000/len 255, 0x400/len 255, 0x800/len 87; then done.
3. base 0xFF0, nwords 8 -> addr 0xFF0/len 3 then 0x1000/len 3 (4 KB split).
4. nwords 0 -> done 2 cycles after start, run never high. base 0x2 -> done with err=1, run never high.
5. Engine returns error=1 on burst 1 of the 600-word case -> no second run; done with err=1. The next clean start clears err.
6. Assert rst while in WAIT -> next cycle run=0, busy=0, done=0, err=0. start while busy -> ignored, no extra bursts.

Source files
------------

// File: rtl/iob2axi_rd_split_pkg.sv
// iob2axi_rd_split_pkg: shared constants for the read-request burst splitter.
package iob2axi_rd_split_pkg;
  localparam int AXI_LEN_W = 8;
  localparam int BOUNDARY_DEF = 4096;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CALC = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
endpackage

// File: rtl/iob2axi_burst_len.sv
// iob2axi_burst_len: beats in next burst = min(remaining, MAX_BURST, beats to boundary).
module iob2axi_burst_len #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int MAX_BURST = 256,
  parameter int BOUNDARY = 4096
) (
  input  logic [ADDR_W-1:0]            cur_addr,
  input  logic [CNT_W-1:0]             rem,
  output logic [$clog2(MAX_BURST):0]   blen
);
  localparam int SH = $clog2(DATA_W/8);
  localparam int BL_W = $clog2(MAX_BURST) + 1;
  logic [31:0] off, beats, lim;
  always_comb begin
    off = 32'(cur_addr) & 32'(BOUNDARY - 1);
    beats = (32'(BOUNDARY) - off) >> SH;
    lim = beats < 32'(MAX_BURST) ? beats : 32'(MAX_BURST);
    blen = BL_W'(32'(rem) < lim ? 32'(rem) : lim);
  end
endmodule

// File: rtl/iob2axi_rd_split.sv
// iob2axi_rd_split: splits one word-aligned read request into legal AXI INCR bursts.
module iob2axi_rd_split
  import iob2axi_rd_split_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int MAX_BURST = 256,
  parameter int BOUNDARY = BOUNDARY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     nwords,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 run,
  output logic [ADDR_W-1:0]    addr,
  output logic [AXI_LEN_W-1:0] length,
  input  logic                 ready,
  input  logic                 error
);
  localparam int SH = $clog2(DATA_W/8);
  localparam int BL_W = $clog2(MAX_BURST) + 1;
  logic [2:0] state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0] rem;
  logic [BL_W-1:0] blen, blen_q;
  logic misaligned;
  iob2axi_burst_len #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .MAX_BURST(MAX_BURST), .BOUNDARY(BOUNDARY)
  ) u_len (
    .cur_addr(cur_addr), .rem(rem), .blen(blen)
  );
  assign misaligned = (base_addr & ADDR_W'((DATA_W/8) - 1)) != '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // run drops combinationally in the cycle the engine deasserts ready
  assign run = state == ISSUE && ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      rem <= '0;
      blen_q <= '0;
      addr <= '0;
      length <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur_addr <= base_addr;
          rem <= nwords;
          err <= misaligned;
          state <= (misaligned || nwords == '0) ? DONE : CALC;
        end
        CALC: begin
          addr <= cur_addr;
          length <= AXI_LEN_W'(blen - BL_W'(1));
          blen_q <= blen;
          state <= ISSUE;
        end
        ISSUE: if (!ready) state <= WAIT;
        WAIT: if (ready) begin
          cur_addr <= cur_addr + (ADDR_W'(blen_q) << SH);
          rem <= rem - CNT_W'(blen_q);
          err <= error;
          state <= (error || rem == CNT_W'(blen_q)) ? DONE : CALC;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
